// File: rtl/button_autorepeat_pkg.sv
// Shared button types and default timing for all button consumers.
package button_autorepeat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEATING  = 3'd3,
    ST_RELEASE_DB = 3'd4
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_HOLD_CYCLES     = 25000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 5000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_autorepeat_sync.sv
// Two-flop synchronizer for the raw asynchronous button level.
module btn_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_autorepeat.sv
// Debounced button with press pulse, hold-to-repeat and long-press event.
// Macro BUTTON_AUTOREPEAT_LONG_PRESS_EN enables the long_press register.
module button_autorepeat
  import button_autorepeat_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic repeat_en,
  output logic pulse,
  output logic pressed,
  output logic long_press
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic          sync;
  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pulse_nxt, pressed_nxt;
  logic          hold_hit;

  btn_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (sync)
  );

  assign hold_hit = (state == ST_HELD) && sync && (cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pulse   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse   <= pulse_nxt;
      pressed <= pressed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sync) begin
          state_nxt = ST_PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!sync) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (hold_hit) begin
          state_nxt = ST_REPEATING;
          cnt_nxt   = '0;
          pulse_nxt = repeat_en;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // Timer free-runs regardless of repeat_en so the repeat phase is kept.
      ST_REPEATING: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt   = '0;
          pulse_nxt = repeat_en;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        if (sync) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    pressed_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_REPEATING) ||
                  (state_nxt == ST_RELEASE_DB);
  end

`ifdef BUTTON_AUTOREPEAT_LONG_PRESS_EN
  always_ff @(posedge clk) begin
    if (reset) long_press <= 1'b0;
    else       long_press <= hold_hit;
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_autorepeat.sv
// Self-checking bench: per-cycle compare against an edge-counting model plus literal timing pins.
module tb_button_autorepeat;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;
  logic repeat_en = 1'b0;
  logic pulse, pressed, long_press;

  button_autorepeat #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .repeat_en  (repeat_en),
    .pulse      (pulse),
    .pressed    (pressed),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0       = 0;

  // Model: phases of a press, measured by counting edges.
  localparam int P_IDLE = 0, P_PRESSING = 1, P_HELD = 2, P_RELEASING = 3;
  int   phase = P_IDLE;
  int   run   = 0;
  int   age   = 0;
  logic h0 = 1'b0, h1 = 1'b0;
  logic exp_pulse = 1'b0, exp_pressed = 1'b0, exp_lp = 1'b0;
  logic prev_pressed = 1'b0;

  int pulse_log[$];
  int lp_log[$];
  int rise_log[$];
  int fall_log[$];

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, cyc, act, want);
    end
  endtask

  task automatic model_edge();
    logic s;
    if (reset) begin
      h0 = 1'b0; h1 = 1'b0; phase = P_IDLE; run = 0; age = 0;
      exp_pulse = 1'b0; exp_lp = 1'b0; exp_pressed = 1'b0;
      return;
    end
    s  = h1;
    h1 = h0;
    h0 = btn;
    exp_pulse = 1'b0;
    exp_lp    = 1'b0;
    case (phase)
      P_IDLE: if (s) begin phase = P_PRESSING; run = 0; end
      P_PRESSING: begin
        if (!s) phase = P_IDLE;
        else begin
          run++;
          if (run == D) begin phase = P_HELD; age = 0; exp_pulse = 1'b1; end
        end
      end
      P_HELD: begin
        if (!s) begin phase = P_RELEASING; run = 0; end
        else begin
          age++;
          if (age == H) begin
            exp_pulse = repeat_en;
`ifdef BUTTON_AUTOREPEAT_LONG_PRESS_EN
            exp_lp = 1'b1;
`endif
          end else if (age > H && (age - H) % R == 0) begin
            exp_pulse = repeat_en;
          end
        end
      end
      default: begin
        if (s) run = 0;
        else begin
          run++;
          if (run == D) phase = P_IDLE;
        end
      end
    endcase
    exp_pressed = (phase == P_HELD) || (phase == P_RELEASING);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("pulse", int'(pulse), int'(exp_pulse));
    check("pressed", int'(pressed), int'(exp_pressed));
    check("long_press", int'(long_press), int'(exp_lp));
    if (pulse) pulse_log.push_back(cyc - e0);
    if (long_press) lp_log.push_back(cyc - e0);
    if (pressed && !prev_pressed) rise_log.push_back(cyc - e0);
    if (!pressed && prev_pressed) fall_log.push_back(cyc - e0);
    prev_pressed = pressed;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_press();
    pulse_log.delete(); lp_log.delete(); rise_log.delete(); fall_log.delete();
    e0  = cyc + 1;
    btn = 1'b1;
  endtask

  task automatic check_list(input string name, input int got[$], input int want[$]);
    check({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check(name, got[i], want[i]);
  endtask

  initial begin
    int w_single[$];
    int w_none[$];
    int w_rep[$];
    int w_lp[$];
    int w_gate[$];
    int w_rst[$];
    int w_fall[$];

    w_single = '{6};
    w_none   = {};
    w_rep    = '{6, 26, 31, 36, 41, 46};
    w_gate   = '{6, 36, 41, 46};
    w_rst    = '{6, 26, 37};
`ifdef BUTTON_AUTOREPEAT_LONG_PRESS_EN
    w_lp = '{26};
`else
    w_lp = {};
`endif

    run_n(2);
    reset = 1'b0;
    run_n(3);
    check("reset_pulse", int'(pulse), 0);
    check("reset_pressed", int'(pressed), 0);
    check("reset_long_press", int'(long_press), 0);

    // Short press and release
    start_press();
    run_n(10);
    btn = 1'b0;
    run_n(20);
    check_list("short_pulses", pulse_log, w_single);
    check_list("short_rise", rise_log, w_single);
    w_fall = '{16};
    check_list("short_fall", fall_log, w_fall);
    check_list("short_lp", lp_log, w_none);

    // Glitches shorter than the debounce window
    start_press();
    run_n(3);
    btn = 1'b0; run_n(1);
    btn = 1'b1; run_n(2);
    btn = 1'b0; run_n(20);
    check_list("glitch_pulses", pulse_log, w_none);
    check_list("glitch_rise", rise_log, w_none);

    // Long hold with repeat
    repeat_en = 1'b1;
    start_press();
    run_n(48);
    btn = 1'b0;
    run_n(20);
    check_list("repeat_pulses", pulse_log, w_rep);
    check_list("repeat_lp", lp_log, w_lp);

    // Long hold, repeat enabled late
    repeat_en = 1'b0;
    start_press();
    run_n(33);
    repeat_en = 1'b1;
    run_n(15);
    btn = 1'b0;
    run_n(20);
    check_list("gated_pulses", pulse_log, w_gate);
    check_list("gated_lp", lp_log, w_lp);

    // Reset mid-hold, button kept down
    start_press();
    run_n(30);
    reset = 1'b1;
    step();
    check("midreset_pulse", int'(pulse), 0);
    check("midreset_pressed", int'(pressed), 0);
    check("midreset_long_press", int'(long_press), 0);
    reset = 1'b0;
    run_n(15);
    btn = 1'b0;
    run_n(20);
    check_list("reset_pulses", pulse_log, w_rst);

    // Release bounce restarts the release debounce
    start_press();
    run_n(10);
    btn = 1'b0; run_n(2);
    btn = 1'b1; run_n(1);
    btn = 1'b0; run_n(20);
    check_list("bounce_pulses", pulse_log, w_single);
    w_fall = '{18};
    check_list("bounce_fall", fall_log, w_fall);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_autorepeat.md
BUTTON_AUTOREPEAT -- requirements
Module: button_autorepeat

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000; consecutive stable samples required to accept a press or a release (legal range 2 or more).
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000; cycles a press is held before repeating starts (must exceed DEBOUNCE_CYCLES).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 5000000; period between auto-repeat pulses (2 or more).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port btn  input  1  raw asynchronous button level, active high.
REQ-007 SHALL have port repeat_en  input  1  enables auto-repeat pulses; sampled every cycle.
REQ-008 SHALL have port pulse  output  1  one-cycle registered event, feeding a game's inc/dec/roll input.
REQ-009 SHALL have port pressed  output  1  registered debounced button level.
REQ-010 SHALL have port long_press  output  1  one-cycle registered event when the hold threshold is reached.

Function
REQ-011 SHALL pass btn through a 2-flop synchronizer; all decisions use the second flop (sync).
REQ-012 SHALL implement the FSM states IDLE, PRESS_DB, HELD, REPEATING and RELEASE_DB, with one shared counter cnt sized to the largest parameter.
REQ-013 IDLE: sync=1 -> PRESS_DB with cnt=0.
REQ-014 PRESS_DB: sync=0 -> IDLE with no output; else cnt++; sync=1 with cnt=DEBOUNCE_CYCLES-1 -> HELD, cnt=0, pulse=1.
REQ-015 With btn stable high from the first sampling edge E0, pulse SHALL be high for exactly the cycle after edge E0+DEBOUNCE_CYCLES+2.
REQ-016 HELD: sync=0 -> RELEASE_DB, cnt=0; else cnt++; cnt=HOLD_CYCLES-1 -> REPEATING, cnt=0, long_press=1, and pulse=repeat_en.
REQ-017 REPEATING: sync=0 -> RELEASE_DB, cnt=0; else cnt++; cnt=REPEAT_CYCLES-1 -> cnt=0, pulse=repeat_en.
REQ-018 RELEASE_DB: sync=1 -> cnt=0, stay in RELEASE_DB, no pulse (a release bounce never re-triggers); sync=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-019 pressed SHALL be 1 exactly while the state is HELD, REPEATING or RELEASE_DB; release latency is symmetric with press latency (DEBOUNCE_CYCLES+2 edges).
REQ-020 A high glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no pressed.
REQ-021 repeat_en SHALL gate only the pulse; the repeat timer SHALL keep running regardless of repeat_en, so toggling repeat_en mid-hold keeps the repeat phase.
REQ-022 pulse and long_press SHALL never be high for two consecutive cycles except on REPEAT_CYCLES-spaced events; pulse count per press is 1 + repeats.

Reset
REQ-023 reset SHALL clear the synchronizer flops, cnt, pulse, pressed and long_press to 0 and force IDLE on the next edge, including mid-press.
REQ-024 After reset, a button still held SHALL be treated as a new press (full debounce, new pulse).

Configuration
REQ-025 Macro BUTTON_AUTOREPEAT_LONG_PRESS_EN defined: long_press behaves per REQ-016.
REQ-026 Macro BUTTON_AUTOREPEAT_LONG_PRESS_EN undefined: long_press is tied to constant 0 and no register is inferred; all other behaviour is unchanged.

Structure
REQ-027 FSM state encoding (3-bit localparams) and the default timing constants SHALL live in the shared game package/include, reused by other button consumers.
REQ-028 The 2-flop synchronizer SHALL be a sub-module named btn_sync2 (ports clk, reset, d, q).

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, macro defined unless stated)
REQ-029 btn high 10 cycles from E0, then low at R0 -> single pulse after E0+6, pressed rises at E0+6, falls at R0+6, no long_press.
REQ-030 btn high 3 cycles, low 1, high 2, low -> pulse and pressed stay 0 throughout.
REQ-031 btn high 48 cycles, repeat_en=1 -> pulses after E0+6, 26, 31, 36, 41, 46 (6 total), long_press only at 26.
REQ-032 Same stimulus with repeat_en=0 -> one pulse at E0+6, long_press at 26, no further pulses; raising repeat_en at E0+33 -> pulses at 36, 41, 46.
REQ-033 reset for 1 cycle at E0+30 with btn held -> all outputs 0 after that edge, then new pulse 6 edges after reset release.
REQ-034 Macro undefined, scenario REQ-031 -> identical pulse train, long_press constantly 0.
